// File: rtl/magic_pkg.sv
// Shared types and sizes for the MAGIC NOR/INV sequential executor.
// The op program is a flat list of {op, a, b, y} records terminated by OP_END.
package magic_pkg;
  localparam int N_CELLS    = 128;
  localparam int CELL_W     = 7;
  localparam int N_IN       = 7;
  localparam int N_OUT      = 4;
  localparam int OUT_IDX_W  = 2;
  localparam int PROG_DEPTH = 128;
  localparam int PC_W       = 7;

  typedef enum logic [1:0] {
    OP_NOR2 = 2'd0,
    OP_INV1 = 2'd1,
    OP_OUT  = 2'd2,
    OP_END  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_INIT = 3'd2,
    S_EVAL = 3'd3,
    S_OUTC = 3'd4,
    S_DONE = 3'd5
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [CELL_W-1:0] a;
    logic [CELL_W-1:0] b;
    logic [CELL_W-1:0] y;
  } op_t;

  // State entered when an op is fetched for execution.
  function automatic state_e decode_op(op_e o);
    case (o)
      OP_NOR2, OP_INV1: return S_INIT;
      OP_OUT:           return S_OUTC;
      default:          return S_DONE;
    endcase
  endfunction
endpackage

// File: rtl/magic_nor_executor_if.sv
// Program-load, start and result signals of the executor, grouped for one port.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface magic_nor_executor_if;
  import magic_pkg::*;

  logic              prog_we;
  logic [PC_W-1:0]   prog_addr;
  logic [1:0]        prog_op;
  logic [CELL_W-1:0] prog_a;
  logic [CELL_W-1:0] prog_b;
  logic [CELL_W-1:0] prog_y;
  logic              start_valid;
  logic              start_ready;
  logic [N_IN-1:0]   in_vec;
  logic              res_valid;
  logic              res_ready;
  logic [N_OUT-1:0]  res_vec;
  logic              busy;
  logic              prog_err;
  logic [15:0]       cycle_count;
  state_e            dbg_state;

  modport master (
    output prog_we, prog_addr, prog_op, prog_a, prog_b, prog_y,
    output start_valid, in_vec, res_ready,
    input  start_ready, res_valid, res_vec, busy, prog_err, cycle_count, dbg_state
  );

  modport slave (
    input  prog_we, prog_addr, prog_op, prog_a, prog_b, prog_y,
    input  start_valid, in_vec, res_ready,
    output start_ready, res_valid, res_vec, busy, prog_err, cycle_count, dbg_state
  );
endinterface

// File: rtl/magic_cell_array.sv
// 1-bit memristive cell array: two combinational read ports, one write port,
// a parallel preload of the primary inputs and an asynchronous clear.
module magic_cell_array
  import magic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CELL_W-1:0] ra_a,
  input  logic [CELL_W-1:0] ra_b,
  output logic              rd_a,
  output logic              rd_b,
  input  logic              we,
  input  logic [CELL_W-1:0] wa,
  input  logic              wd,
  input  logic              load_en,
  input  logic [N_IN-1:0]   load_vec
);
  logic [N_CELLS-1:0] cells;

  // Out-of-range addresses match no cell: writes drop, reads return 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cells <= '0;
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (load_en) cells[k] <= load_vec[k];
      end
      for (int i = 0; i < N_CELLS; i++) begin
        if (we && wa == CELL_W'(i)) cells[i] <= wd;
      end
    end
  end

  always_comb begin
    rd_a = 1'b0;
    rd_b = 1'b0;
    for (int i = 0; i < N_CELLS; i++) begin
      if (ra_a == CELL_W'(i)) rd_a = cells[i];
      if (ra_b == CELL_W'(i)) rd_b = cells[i];
    end
  end
endmodule

// File: rtl/magic_nor_executor.sv
// Sequential MAGIC-order evaluator of a NOR/INV op program over the cell array:
// each gate is an init-to-1 step followed by a conditional NOR evaluate.
module magic_nor_executor
  import magic_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  magic_nor_executor_if.slave  bus
);
  op_t mem [PROG_DEPTH];

  state_e            state, state_n;
  logic [PC_W-1:0]   pc, pc_n, pc_inc;
  logic [N_IN-1:0]   in_lat;
  logic [N_OUT-1:0]  res_q, res_n;
  logic              err_q, err_n;
  logic [15:0]       cnt_q, cnt_n;
  logic              accept, last_op, mem_we;
  op_t               cur;
  op_e               nxt_op;
  logic              cell_we, cell_wd, load_en, rd_a, rd_b;

  assign accept  = bus.start_valid && (state == S_IDLE);
  assign pc_inc  = pc + PC_W'(1);
  assign last_op = (pc == PC_W'(PROG_DEPTH - 1));
  assign cur     = mem[pc];
  assign nxt_op  = mem[pc_inc].op;

  // Op memory is deliberately not reset so a program survives an abort.
  always_ff @(posedge clk) begin
    if (mem_we) mem[bus.prog_addr] <= op_t'({bus.prog_op, bus.prog_a, bus.prog_b, bus.prog_y});
  end

  magic_cell_array u_cells (
    .clk      (clk),
    .rst      (rst),
    .ra_a     (cur.a),
    .ra_b     (cur.b),
    .rd_a     (rd_a),
    .rd_b     (rd_b),
    .we       (cell_we),
    .wa       (cur.y),
    .wd       (cell_wd),
    .load_en  (load_en),
    .load_vec (in_lat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= '0;
      in_lat <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      res_q <= res_n;
      err_q <= err_n;
      cnt_q <= cnt_n;
      if (accept) in_lat <= bus.in_vec;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    res_n   = res_q;
    err_n   = err_q;
    cnt_n   = cnt_q;
    mem_we  = 1'b0;
    cell_we = 1'b0;
    cell_wd = 1'b1;
    load_en = 1'b0;
    // Every edge of an active run, including the one entering DONE, is counted.
    if (state != S_IDLE && state != S_DONE && cnt_q != 16'hFFFF) cnt_n = cnt_q + 16'd1;
    case (state)
      S_IDLE: begin
        mem_we = bus.prog_we;
        if (accept) begin
          state_n = S_LOAD;
          pc_n    = '0;
          err_n   = 1'b0;
          cnt_n   = 16'd1;
        end
      end
      S_LOAD: begin
        load_en = 1'b1;
        res_n   = '0;
        pc_n    = '0;
        state_n = decode_op(cur.op);
      end
      S_INIT: begin
        cell_we = 1'b1;
        state_n = S_EVAL;
      end
      S_EVAL, S_OUTC: begin
        if (state == S_EVAL) begin
          cell_we = 1'b1;
          cell_wd = (cur.op == OP_NOR2) ? ~(rd_a | rd_b) : ~rd_a;
        end else begin
          res_n[cur.b[OUT_IDX_W-1:0]] = rd_a;
        end
        if (last_op) begin
          err_n   = 1'b1;
          state_n = S_DONE;
        end else begin
          pc_n    = pc_inc;
          state_n = decode_op(nxt_op);
        end
      end
      S_DONE: begin
        if (bus.res_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.start_ready = (state == S_IDLE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.res_valid   = (state == S_DONE);
  assign bus.res_vec     = res_q;
  assign bus.prog_err    = err_q;
  assign bus.cycle_count = cnt_q;
  assign bus.dbg_state   = state;
endmodule

// File: tb/tb_magic_nor_executor.sv
// Bench for magic_nor_executor: programs are built here, the expected result of each
// run comes from a behavioural interpreter of the op list over a bit array.
module tb_magic_nor_executor;
  import magic_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  magic_nor_executor_if bus();

  magic_nor_executor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [N_OUT-1:0] exp_q[$];

  // Mirror of the op memory contents and model cell state.
  int   p_op [PROG_DEPTH];
  int   p_a  [PROG_DEPTH];
  int   p_b  [PROG_DEPTH];
  int   p_y  [PROG_DEPTH];
  int   plen;
  int   nxt_cell;
  logic m_cell [N_CELLS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input int op, input int a, input int b, input int y);
    p_op[plen] = op; p_a[plen] = a; p_b[plen] = b; p_y[plen] = y;
    plen++;
  endtask

  task automatic g_nor(input int a, input int b, output int y);
    y = nxt_cell; nxt_cell++;
    put(0, a, b, y);
  endtask

  task automatic g_inv(input int a, output int y);
    y = nxt_cell; nxt_cell++;
    put(1, a, 0, y);
  endtask

  task automatic g_xnor(input int a, input int b, output int y);
    int n1, n2, n3;
    g_nor(a, b, n1); g_nor(a, n1, n2); g_nor(b, n1, n3); g_nor(n2, n3, y);
  endtask

  task automatic g_xor3(input int a, input int b, input int c, output int y);
    int t;
    g_xnor(a, b, t); g_xnor(t, c, y);
  endtask

  task automatic g_maj(input int a, input int b, input int c, output int y);
    int p, q, r, t, u;
    g_nor(a, b, p); g_nor(a, c, q); g_nor(b, c, r);
    g_nor(p, q, t); g_inv(t, u); g_nor(u, r, y);
  endtask

  // Bit 1 of popcount(7 inputs) from full-adder carries, padded to 111 gates.
  task automatic build_rd73f1();
    int s1, c1, s2, c2, c3, r, d;
    plen = 0; nxt_cell = N_IN;
    g_xor3(0, 1, 2, s1); g_maj(0, 1, 2, c1);
    g_xor3(3, 4, 5, s2); g_maj(3, 4, 5, c2);
    g_maj(s1, s2, 6, c3);
    g_xor3(c1, c2, c3, r);
    while (plen < 111) g_nor($urandom_range(0, nxt_cell - 1), $urandom_range(0, nxt_cell - 1), d);
    put(2, r, 0, 0);
    put(3, 0, 0, 0);
  endtask

  task automatic load_prog();
    for (int i = 0; i < plen; i++) begin
      @(negedge clk);
      bus.prog_we = 1'b1; bus.prog_addr = PC_W'(i); bus.prog_op = 2'(p_op[i]);
      bus.prog_a = CELL_W'(p_a[i]); bus.prog_b = CELL_W'(p_b[i]); bus.prog_y = CELL_W'(p_y[i]);
    end
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  // Executes the op list in program order; edges = accept edge + LOAD + 2 per gate + 1 per OUT.
  task automatic model_run(input logic [N_IN-1:0] iv, output logic [N_OUT-1:0] res,
                           output int edges, output logic err);
    for (int k = 0; k < N_IN; k++) m_cell[k] = iv[k];
    res = '0; edges = 2; err = 1'b0;
    for (int p = 0; p < PROG_DEPTH; p++) begin
      if (p_op[p] == 3) break;
      if (p_op[p] == 2) begin
        res[p_b[p] % N_OUT] = m_cell[p_a[p]];
        edges += 1;
      end else begin
        m_cell[p_y[p]] = 1'b1;
        m_cell[p_y[p]] = ~(m_cell[p_a[p]] | ((p_op[p] == 0) ? m_cell[p_b[p]] : 1'b0));
        edges += 2;
      end
      if (p == PROG_DEPTH - 1) err = 1'b1;
    end
  endtask

  task automatic start_run(input logic [N_IN-1:0] iv);
    @(negedge clk);
    check("start_ready_idle", bus.start_ready, 1);
    bus.in_vec = iv; bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    check("busy_after_accept", bus.busy, 1);
    check("err_cleared", bus.prog_err, 0);
  endtask

  task automatic run(input logic [N_IN-1:0] iv, input bit poke, input int hold);
    logic [N_OUT-1:0] er;
    int ee, n;
    logic eerr;
    model_run(iv, er, ee, eerr);
    exp_q.push_back(er);
    start_run(iv);
    if (poke) begin
      bus.prog_we = 1'b1; bus.prog_addr = PC_W'(1); bus.prog_op = 2'd3;
      @(negedge clk);
      bus.prog_we = 1'b0;
    end
    n = 0;
    while (!bus.res_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("res_valid", bus.res_valid, 1);
    check("res_vec", bus.res_vec, exp_q.pop_front());
    check("cycle_count", bus.cycle_count, ee);
    check("prog_err", bus.prog_err, eerr);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("bp_res_valid", bus.res_valid, 1);
      check("bp_res_vec", bus.res_vec, er);
      check("bp_start_ready", bus.start_ready, 0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("idle_after_hs", bus.start_ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_IN-1:0] iv;
    int start, n;
    for (int i = 0; i < PROG_DEPTH; i++) begin
      p_op[i] = 3; p_a[i] = 0; p_b[i] = 0; p_y[i] = 0;
    end
    for (int i = 0; i < N_CELLS; i++) m_cell[i] = 1'b0;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_op = '0;
    bus.prog_a = '0; bus.prog_b = '0; bus.prog_y = '0;
    bus.start_valid = 1'b0; bus.in_vec = '0; bus.res_ready = 1'b0;

    // Clock/reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_res_vec", bus.res_vec, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_prog_err", bus.prog_err, 0);
    check("rst_cycle_count", bus.cycle_count, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_start_ready", bus.start_ready, 1);
    rst = 1'b0;

    // Single NOR; the poked write during the first run must be ignored.
    plen = 0;
    put(0, 0, 1, 7); put(2, 7, 0, 0); put(3, 0, 0, 0);
    load_prog();
    run(7'd0, 1'b1, 0);
    run(7'd0, 1'b0, 0);
    check("nor_00", bus.res_vec[0], 1);
    run(7'b0000001, 1'b0, 0);
    check("nor_01", bus.res_vec[0], 0);
    run(7'b0000011, 1'b0, 0);
    for (int i = 0; i < 3; i++) run(N_IN'($urandom_range(0, 127)), 1'b0, 0);

    // Backpressure
    run(N_IN'($urandom_range(0, 127)), 1'b0, 10);

    // Alias: destination equals operand
    plen = 0;
    put(1, 7, 0, 7); put(2, 7, 0, 0); put(3, 0, 0, 0);
    load_prog();
    for (int i = 0; i < 4; i++) begin
      run(N_IN'($urandom_range(0, 127)), 1'b0, 0);
      check("alias_zero", bus.res_vec[0], 0);
    end

    // rd73f1 sweep
    build_rd73f1();
    load_prog();
    start = $urandom_range(0, 127);
    for (int i = 0; i < 128; i++) begin
      iv = N_IN'((start + i) % 128);
      run(iv, 1'b0, 0);
      check("popcnt_bit1", bus.res_vec[0], ($countones(iv) >> 1) & 1);
    end

    // Missing END, then a following start clears prog_err
    plen = 0;
    for (int i = 0; i < PROG_DEPTH; i++)
      put(0, $urandom_range(0, N_CELLS - 1), $urandom_range(0, N_CELLS - 1), $urandom_range(0, N_CELLS - 1));
    load_prog();
    run(N_IN'($urandom_range(0, 127)), 1'b0, 0);
    plen = 0;
    put(0, 0, 1, 7); put(2, 7, 0, 0); put(3, 0, 0, 0);
    load_prog();
    run(N_IN'($urandom_range(0, 127)), 1'b0, 0);

    // Reset mid-EVAL of rd73f1, then rerun without reloading
    build_rd73f1();
    load_prog();
    iv = N_IN'($urandom_range(0, 127));
    begin
      logic [N_OUT-1:0] er;
      int ee;
      logic eerr;
      model_run(iv, er, ee, eerr);
      exp_q.push_back(er);
    end
    start_run(iv);
    repeat (60) @(negedge clk);
    n = 0;
    while (bus.dbg_state != S_EVAL && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("in_eval_before_rst", bus.dbg_state, S_EVAL);
    #2 rst = 1'b1;
    #1;
    check("abort_res_valid", bus.res_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_start_ready", bus.start_ready, 1);
    void'(exp_q.pop_front());
    for (int i = 0; i < N_CELLS; i++) m_cell[i] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run(iv, 1'b0, 0);
    check("rerun_popcnt_bit1", bus.res_vec[0], ($countones(iv) >> 1) & 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
